// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive path and the future transmit path:
// the frame FSM state encoding, the oversampling ratio and the even-parity
// helper used by the optional parity stage.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // True when data bits plus parity bit hold an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// First-word fall-through FIFO: the head entry is always presented on rd_data
// while rd_valid is high. A write accepted while full is only possible
// together with a pop in the same cycle.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   wr_en      write request (dropped when full and no pop)
//   wr_data    WIDTH-bit write data
//   rd_en      pop request, ignored when empty
//   rd_data    head entry
//   rd_valid   FIFO non-empty
//   full       occupancy equals DEPTH
//   count      occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    assign empty_s  = (count_r == (AW+1)'(0));
    assign full_s   = (count_r == (AW+1)'(DEPTH));
    assign pop_s    = rd_en & ~empty_s;
    // When full, the slot being written is the one being popped this cycle.
    assign push_s   = wr_en & (~full_s | pop_s);

    assign rd_data  = mem_r[rd_ptr_r];
    assign rd_valid = ~empty_s;
    assign full     = full_s;
    assign count    = count_r;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 16x oversampled UART receiver feeding a byte FIFO, with RTS flow control
// derived from FIFO occupancy. Default frame is 8N1; defining the macro
// UART_RX_PARITY_EN switches to 8E1 and adds the parity_err output.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rx          serial input (idle high, asynchronous to clk)
//   rts         active-low request-to-send, 1 = stop sending
//   rd_data     FIFO head byte, valid while rd_valid=1
//   rd_valid    FIFO non-empty
//   rd_en       pop head (ignored when empty)
//   count       FIFO occupancy
//   frame_err   1-cycle pulse: stop bit sampled 0
//   overrun     1-cycle pulse: byte dropped because FIFO full
//   parity_err  (UART_RX_PARITY_EN only) 1-cycle pulse: even parity failed
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DEPTH      = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic                   rts,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    input  logic                   rd_en,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_err,
    output logic                   overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic           rx_meta_r;
    logic           rx_sync_r;
    logic [TW-1:0]  tick_cnt_r;
    logic           tick_s;
    uart_state_t    state_r;
    logic [3:0]     phase_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic           wait_high_r;
    logic           push_r;
    logic           frame_err_r;
    logic           overrun_r;
    logic           rts_r;
    logic           fifo_full_s;
    logic           fifo_wr_s;
    logic [CW-1:0]  count_s;
`ifdef UART_RX_PARITY_EN
    logic           parity_err_r;
`endif

    // Two-flop synchroniser for the asynchronous rx line, idle-high at reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign tick_s = (tick_cnt_r == TW'(DIV - 1));

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= TW'(0);
        end else if (tick_s) begin
            tick_cnt_r <= TW'(0);
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Frame FSM: start validation at mid-bit, then one sample per 16 ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            phase_r      <= 4'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            wait_high_r  <= 1'b0;
            push_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            push_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    // After a framing error the line must return high
                    // before a new falling edge is treated as a start bit.
                    if (wait_high_r) begin
                        if (rx_sync_r) begin
                            wait_high_r <= 1'b0;
                        end
                    end else if (!rx_sync_r) begin
                        phase_r <= 4'd0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (phase_r == 4'd7) begin
                            if (rx_sync_r) begin
                                state_r <= IDLE;
                            end else begin
                                state_r   <= DATA;
                                bit_idx_r <= 3'd0;
                                phase_r   <= 4'd0;
                            end
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (phase_r == 4'd15) begin
                            shift_r   <= {rx_sync_r, shift_r[7:1]};
                            phase_r   <= 4'd0;
                            bit_idx_r <= bit_idx_r + 3'd1;
                            if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_r <= PARITY;
`else
                                state_r <= STOP;
`endif
                            end
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        if (phase_r == 4'd15) begin
`ifdef UART_RX_PARITY_EN
                            parity_err_r <= ~even_parity_ok(shift_r, rx_sync_r);
`endif
                            phase_r <= 4'd0;
                            state_r <= STOP;
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (phase_r == 4'd15) begin
                            if (rx_sync_r) begin
                                push_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                                wait_high_r <= 1'b1;
                            end
                            phase_r <= 4'd0;
                            state_r <= IDLE;
                        end else begin
                            phase_r <= phase_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // A completed byte is dropped only if the FIFO is full and not popping.
    assign fifo_wr_s = push_r & (~fifo_full_s | rd_en);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr_s),
        .wr_data  (shift_r),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (fifo_full_s),
        .count    (count_s)
    );

    // Overrun pulse and occupancy-based RTS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
            rts_r     <= 1'b1;
        end else begin
            overrun_r <= push_r & fifo_full_s & ~rd_en;
            rts_r     <= (count_s >= CW'(DEPTH - RTS_MARGIN));
        end
    end

    assign rts        = rts_r;
    assign count      = count_s;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (8N1 build, DIV=4, 64 clk per bit).
module tb_uart_rx_fifo;

    localparam int CLK_HZ     = 6_400_000;
    localparam int BAUD       = 100_000;
    localparam int DEPTH      = 16;
    localparam int RTS_MARGIN = 4;
    localparam int BITP       = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       rts;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .RTS_MARGIN(RTS_MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rts(rts), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_en(rd_en), .count(count),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;
    int ferr_exp  = 0;
    int ovr_exp   = 0;
    logic [7:0] model_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         glitch;
        int         exp_count;
        int         exp_ferr;
    } vec_t;
    vec_t tbl[4];

    // Count error pulse samples; a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (frame_err === 1'b1) ferr_seen++;
            if (overrun === 1'b1) ovr_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (BITP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITP) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BITP) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic glitch(input int n);
        @(negedge clk);
        rx = 1'b0;
        repeat (n) @(negedge clk);
        rx = 1'b1;
        repeat (BITP) @(negedge clk);
    endtask

    // Reference model: a completed good frame enters the queue unless it is full.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) ferr_exp++;
        else if (model_q.size() == DEPTH) ovr_exp++;
        else model_q.push_back(b);
    endtask

    task automatic check_state(input string name);
        check({name, "_count"}, 32'(count), 32'(model_q.size()));
        check({name, "_valid"}, 32'(rd_valid), 32'(model_q.size() > 0));
        check({name, "_rts"}, 32'(rts), 32'(model_q.size() >= DEPTH - RTS_MARGIN));
        if (model_q.size() > 0) check({name, "_head"}, 32'(rd_data), 32'(model_q[0]));
        check({name, "_ferr"}, 32'(ferr_seen), 32'(ferr_exp));
        check({name, "_ovr"}, 32'(ovr_seen), 32'(ovr_exp));
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       good;
        int         found;
        int         npop;

        tbl[0] = '{data: 8'h00, stop: 1'b1, glitch: 20, exp_count: 0, exp_ferr: 0};
        tbl[1] = '{data: 8'hA5, stop: 1'b1, glitch: 0,  exp_count: 1, exp_ferr: 0};
        tbl[2] = '{data: 8'h3C, stop: 1'b0, glitch: 0,  exp_count: 1, exp_ferr: 1};
        tbl[3] = '{data: 8'h11, stop: 1'b1, glitch: 0,  exp_count: 2, exp_ferr: 1};

        rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rts", 32'(rts), 32'd1);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_rts", 32'(rts), 32'd0);

        // Table: glitch, good byte, bad stop, recovery byte.
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].glitch > 0) glitch(tbl[i].glitch);
            else begin
                send_frame(tbl[i].data, tbl[i].stop);
                model_frame(tbl[i].data, tbl[i].stop);
            end
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            check($sformatf("tbl%0d_ferr", i), 32'(ferr_seen), 32'(tbl[i].exp_ferr));
            check_state($sformatf("tbl%0d", i));
        end
        check("tbl_head_a5", 32'(rd_data), 32'hA5);
        pop_one();
        check("tbl_head_11", 32'(rd_data), 32'h11);
        pop_one();
        check_state("drained");
        pop_one();
        check_state("pop_empty");

        // RTS threshold at 12 entries.
        for (int i = 0; i < 12; i++) begin
            b = 8'(i * 7 + 1);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
            if (i >= 10) check_state($sformatf("fill%0d", i + 1));
        end
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(model_q.pop_front());
        check("pop_count11", 32'(count), 32'd11);
        check("pop_rts_lag", 32'(rts), 32'd1);
        @(negedge clk);
        check("pop_rts_low", 32'(rts), 32'd0);

        // Fill to 16, then one byte into a full FIFO.
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'hC0 + i);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        check_state("full16");
        send_frame(8'hEE, 1'b1);
        model_frame(8'hEE, 1'b1);
        check_state("overrun");

        // Same but popping in the push cycle.
        found = 0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                for (int k = 0; k < 800 && found == 0; k++) begin
                    @(negedge clk);
                    if (dut.push_r === 1'b1) begin
                        found = 1;
                        rd_en = 1'b1;
                        @(negedge clk);
                        rd_en = 1'b0;
                    end
                end
            end
        join
        check("push_seen", 32'(found), 32'd1);
        void'(model_q.pop_front());
        model_q.push_back(8'h5A);
        check_state("full_pop_push");

        // Reset in the middle of a 0xFF frame.
        @(negedge clk);
        rx = 1'b0;
        repeat (BITP) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BITP) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_rts", 32'(rts), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
        model_q.delete();
        repeat (BITP * 8) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_state("after_rst");
        send_frame(8'h42, 1'b1);
        model_frame(8'h42, 1'b1);
        check_state("rx42");

        // Randomised frames and pops against the queue model.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            model_frame(b, good);
            check_state($sformatf("rnd%0d", i));
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                if (model_q.size() > 0) check($sformatf("rnd%0d_pop%0d", i, p), 32'(rd_data), 32'(model_q[0]));
                pop_one();
            end
            @(negedge clk);
            check_state($sformatf("rnd%0d_post", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
